// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams 32-bit instruction words into byte-wide imem, big-endian, then releases the CPU
// Each accepted word is written as four single-byte writes, MSB at the lowest address.
module imem_boot_loader #(
  parameter int IMEM_BYTES = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              pc_init_valid,
  output logic [31:0]       pc_init,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR0  = 3'd1;
  localparam logic [2:0] S_WR1  = 3'd2;
  localparam logic [2:0] S_WR2  = 3'd3;
  localparam logic [2:0] S_WR3  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [31:0] LIMIT = IMEM_BYTES;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W-2:0] cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              first_q, first_d;

  logic              fits;
  logic              writing;
  logic [1:0]        k;

  // ptr is one bit wider than the address so a completely full memory is representable
  assign fits    = (32'(ptr_q) + 32'd4) <= LIMIT;
  assign writing = (state_q == S_WR0) || (state_q == S_WR1) ||
                   (state_q == S_WR2) || (state_q == S_WR3);

  always_comb begin
    k = 2'd0;
    case (state_q)
      S_WR1:   k = 2'd1;
      S_WR2:   k = 2'd2;
      S_WR3:   k = 2'd3;
      default: k = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (fits) begin
            word_d  = in_data;
            last_d  = in_last;
            state_d = S_WR0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WR0: state_d = S_WR1;
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: begin
        ptr_d = ptr_q + (ADDR_W+1)'(4);
        cnt_d = cnt_q + (ADDR_W-1)'(1);
        if (last_q) begin
          state_d = S_DONE;
          first_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    mem_wdata = 8'd0;
    if (writing) begin
      case (k)
        2'd0:    mem_wdata = word_q[31:24];
        2'd1:    mem_wdata = word_q[23:16];
        2'd2:    mem_wdata = word_q[15:8];
        default: mem_wdata = word_q[7:0];
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE) && fits;
  assign mem_we        = writing;
  assign mem_addr      = writing ? (ptr_q[ADDR_W-1:0] + ADDR_W'(k)) : '0;
  // first_q marks the single DONE cycle where the fetch stage loads pc_init while still held
  assign pc_init_valid = (state_q == S_DONE) && first_q;
  assign cpu_hold      = !((state_q == S_DONE) && !first_q);
  assign pc_init       = 32'd0;
  assign load_done     = (state_q == S_DONE);
  assign load_err      = (state_q == S_ERR);
  assign word_count    = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
// A cycle-level reference model predicts every output; table vectors and hand sequences cover corners.
module tb_imem_boot_loader;

  localparam int N = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, reload;
  logic [31:0] in_data;
  logic        in_ready, mem_we, cpu_hold, pc_init_valid, load_done, load_err;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] pc_init;
  logic [8:0]  word_count;

  logic        rst8, v8, l8, rl8;
  logic [31:0] d8;
  logic        in_ready8, mem_we8, cpu_hold8, pcv8, done8, err8;
  logic [2:0]  mem_addr8;
  logic [7:0]  mem_wdata8;
  logic [31:0] pc_init8;
  logic [1:0]  word_count8;

  imem_boot_loader #(.IMEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .pc_init_valid(pc_init_valid),
    .pc_init(pc_init), .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  imem_boot_loader #(.IMEM_BYTES(8), .ADDR_W(3)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(v8), .in_data(d8), .in_last(l8),
    .in_ready(in_ready8), .reload(rl8), .mem_we(mem_we8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .cpu_hold(cpu_hold8), .pc_init_valid(pcv8),
    .pc_init(pc_init8), .load_done(done8), .load_err(err8), .word_count(word_count8)
  );

  int vecs = 0;
  int errs = 0;

  logic [7:0] tb_mem  [0:N-1];
  logic [7:0] exp_mem [0:N-1];
  logic [7:0] mem8    [0:7];

  always @(posedge clk) if (mem_we)  tb_mem[mem_addr] <= mem_wdata;
  always @(posedge clk) if (mem_we8) mem8[mem_addr8]  <= mem_wdata8;

  // Reference model: mode 0 loading, 1 done, 2 error; rem = bytes still to write
  int          m_mode = 0, m_rem = 0, m_ptr = 0, m_cnt = 0, m_age = 0, cyc = 0;
  logic [31:0] m_word = '0;
  logic        m_last = 1'b0;
  bit          chk_en = 1'b0;
  int          acc_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (m_rem > 0) exp_mem[m_ptr + 4 - m_rem] = m_word[8*m_rem-1 -: 8];
    if (rst) begin
      m_mode = 0; m_rem = 0; m_ptr = 0; m_cnt = 0; m_age = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_ptr += 4;
        m_cnt++;
        if (m_last) begin m_mode = 1; m_age = 0; end
      end
    end else if (m_mode == 0) begin
      if (in_valid) begin
        if (m_ptr + 4 <= N) begin
          m_word = in_data; m_last = in_last; m_rem = 4;
          acc_cyc.push_back(cyc);
        end else begin
          m_mode = 2;
        end
      end
    end else if (reload) begin
      m_mode = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_mode == 1) begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    logic [64:0] act, expv;
    bit          wr;
    if (chk_en) begin
      wr   = (m_rem > 0);
      act  = {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, pc_init_valid, pc_init,
              load_done, load_err, word_count};
      expv = {(m_mode == 0 && m_rem == 0 && m_ptr + 4 <= N), wr,
              wr ? 10'(m_ptr + 4 - m_rem) : 10'd0,
              wr ? m_word[8*m_rem-1 -: 8] : 8'd0,
              !(m_mode == 1 && m_age >= 1), (m_mode == 1 && m_age == 0), 32'd0,
              (m_mode == 1), (m_mode == 2), 9'(m_cnt)};
      vecs++;
      if (act !== expv) begin
        errs++;
        $display("FAIL cycle %0d outputs: got %h required %h", cyc, act, expv);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = w; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 200) begin @(negedge clk); n++; end
    chk("wait_done", 64'(load_done), 64'd1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  typedef struct {
    logic [31:0]      w;
    logic [0:3][7:0]  b;
  } vec_t;

  vec_t tbl [4];
  logic [31:0] ws [6];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{32'h8C410021, {8'h8C, 8'h41, 8'h00, 8'h21}};
    tbl[1] = '{32'h8C430021, {8'h8C, 8'h43, 8'h00, 8'h21}};
    tbl[2] = '{32'h00011020, {8'h00, 8'h01, 8'h10, 8'h20}};
    tbl[3] = '{32'h00421020, {8'h00, 8'h42, 8'h10, 8'h20}};
    for (int i = 0; i < N; i++) begin tb_mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    for (int i = 0; i < 8; i++) mem8[i] = 8'h00;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reload = 1'b0;
    rst8 = 1'b1; v8 = 1'b0; d8 = '0; l8 = 1'b0; rl8 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outs", {in_ready, mem_we, cpu_hold, pc_init_valid, load_done, load_err, word_count},
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
    rst = 1'b0; rst8 = 1'b0;

    // basic four-word program from the table
    for (int i = 0; i < 4; i++) send(tbl[i].w, i == 3);
    wait_done();
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++)
        chk($sformatf("tbl_byte%0d", 4*i+b), 64'(tb_mem[4*i+b]), 64'(tbl[i].b[b]));
    chk("tbl_count", 64'(word_count), 64'd4);

    // reload after DONE, overwrite first word, older bytes survive
    repeat (3) @(negedge clk);
    pulse_reload();
    chk("reload_hold", 64'(cpu_hold), 64'd1);
    send(32'hFFFFFFFF, 1'b1);
    wait_done();
    for (int b = 0; b < 4; b++) chk($sformatf("ff_byte%0d", b), 64'(tb_mem[b]), 64'hFF);
    for (int i = 1; i < 4; i++)
      for (int b = 0; b < 4; b++)
        chk($sformatf("kept_byte%0d", 4*i+b), 64'(tb_mem[4*i+b]), 64'(tbl[i].b[b]));

    // reload ignored in IDLE and in WR1
    pulse_reload();
    pulse_reload();
    send(32'h12345678, 1'b0);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    send(32'h9ABCDEF0, 1'b1);
    wait_done();
    chk("ign_reload_count", 64'(word_count), 64'd2);

    // in_valid held high: acceptances every 5 cycles
    pulse_reload();
    acc_cyc.delete();
    for (int i = 0; i < 6; i++) ws[i] = $urandom;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = ws[i]; in_last = (i == 5);
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    chk("stream_accepts", 64'(acc_cyc.size()), 64'd6);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("stream_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd5);
    for (int i = 0; i < 6; i++)
      chk($sformatf("stream_word%0d", i),
          64'({tb_mem[4*i], tb_mem[4*i+1], tb_mem[4*i+2], tb_mem[4*i+3]}), 64'(ws[i]));

    // random sessions with gaps and stray reloads
    for (int s = 0; s < 4; s++) begin
      pulse_reload();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 3) == 0) pulse_reload();
        send($urandom, i == n - 1);
      end
      wait_done();
    end

    // rst during the write of 0x00421020 at ptr 4: only bytes 4 and 5 land
    pulse_reload();
    send(32'h11111111, 1'b0);
    send(32'hCAFEF00D, 1'b1);
    wait_done();
    pulse_reload();
    send(32'hA5A5A5A5, 1'b0);
    send(32'h00421020, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_count", 64'(word_count), 64'd0);
    chk("rst_mid_hold", 64'(cpu_hold), 64'd1);
    chk("rst_mid_b4", 64'(tb_mem[4]), 64'h00);
    chk("rst_mid_b5", 64'(tb_mem[5]), 64'h42);
    chk("rst_mid_b6", 64'(tb_mem[6]), 64'hF0);
    chk("rst_mid_b7", 64'(tb_mem[7]), 64'h0D);

    n = 0;
    for (int i = 0; i < N; i++) if (tb_mem[i] !== exp_mem[i]) n++;
    chk("mem_image_diffs", 64'(n), 64'd0);

    // 8-byte memory: third word overflows
    v8 = 1'b1; d8 = 32'h01020304;
    n = 0;
    while (!in_ready8 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    d8 = 32'h05060708;
    n = 0;
    while (!in_ready8 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    d8 = 32'h090A0B0C;
    n = 0;
    while (word_count8 != 2'd2 && n < 20) begin @(negedge clk); n++; end
    chk("ovf_count", 64'(word_count8), 64'd2);
    chk("ovf_ready", {err8, in_ready8}, 64'b00);
    @(negedge clk);
    v8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_err%0d", i), {err8, cpu_hold8, mem_we8, in_ready8, done8}, 64'b11000);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("ovf_byte%0d", i), 64'(mem8[i]), 64'(i + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
